// File: rtl/sopc_uart_tx_if.sv
// sopc_uart_tx_if -- Avalon-MM slave bus bundle for the UART transmitter.
//   chipselect  slave select
//   address     register index (0 TXDATA, 1 STATUS, 2 DIVISOR, 3 CTRL)
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    32-bit registered read data (latency 1)
//   irq         level interrupt
interface sopc_uart_tx_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output chipselect, address, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  chipselect, address, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/sopc_uart_tx.sv
// sopc_uart_tx -- Avalon-MM UART transmitter. The CPU pushes bytes into a
// 2**FIFO_AW deep FIFO; the FSM serialises them 8N1 (optionally 8E1/8O1) on tx.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    sopc_uart_tx_if.slave (chipselect/address/write_n/writedata/readdata/irq)
//   tx     serial output, idle high, registered
//
// Registers: 0 TXDATA (W push), 1 STATUS (R count/overrun/busy/full/empty, W clears
// overrun), 2 DIVISOR (bit time = DIVISOR+1 clk), 3 CTRL (irq enables).
//
// Build option: define UART_TX_PARITY_EN to add CTRL[2] parity_en / CTRL[3] odd and a
// parity bit between the data bits and the stop bit. Undefined: plain 8N1.
module sopc_uart_tx #(
  parameter int          FIFO_AW   = 4,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic            clk,
  input  logic            reset,
  sopc_uart_tx_if.slave   bus,
  output logic            tx
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam int CTRL_W = 4;
`else
  localparam int CTRL_W = 2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [15:0]        baud_q, baud_d;
  logic [15:0]        div_q, div_d;
  logic [15:0]        div_lat_q, div_lat_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         data_q, data_d;
  logic               tx_q, tx_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               overrun_q, overrun_d;
  logic               done_q, done_d;
  logic [31:0]        readdata_q, readdata_d;
`ifdef UART_TX_PARITY_EN
  logic               par_en_q, par_en_d;
  logic               par_odd_q, par_odd_d;
`endif

  logic wr, push_req, push, pop, start_frame, done_pulse, bit_end;
  logic empty, full, busy;
  logic unused_wdata;

  assign wr       = bus.chipselect & ~bus.write_n;
  assign push_req = wr && (bus.address == 2'd0);
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign busy     = (state_q != S_IDLE);
  assign bit_end  = (baud_q == 16'd0);
  // A full FIFO still accepts a byte when the FSM pops in the same cycle.
  assign push     = push_req && (!full || pop);

  assign unused_wdata = ^bus.writedata[31:16];

  // Transmit FSM. tx_d is the line level for the bit the FSM enters next, so tx
  // is a pure flop and the start bit appears one clock after the pop.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bitcnt_d    = bitcnt_q;
    data_d      = data_q;
    tx_d        = tx_q;
    div_lat_d   = div_lat_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    done_pulse  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) start_frame = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
          tx_d     = data_q[0];
          baud_d   = div_lat_q;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = div_lat_q;
          if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = (^data_q) ^ par_odd_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            tx_d     = data_q[bitcnt_q + 3'd1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          baud_d  = div_lat_q;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // Back-to-back: next start bit follows the stop bit with no idle gap.
          if (!empty) begin
            start_frame = 1'b1;
          end else begin
            state_d    = S_IDLE;
            done_pulse = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame start: pop a byte and freeze divisor/parity config for this frame.
    if (start_frame) begin
      pop       = 1'b1;
      state_d   = S_START;
      tx_d      = 1'b0;
      baud_d    = div_q;
      div_lat_d = div_q;
      data_d    = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      par_en_d  = ctrl_q[2];
      par_odd_d = ctrl_q[3];
`endif
    end
  end

  // FIFO pointers, register file, interrupt flag and read mux.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d  = rd_ptr_q + FIFO_AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    div_d     = div_q;
    ctrl_d    = ctrl_q;
    overrun_d = overrun_q;
    done_d    = done_q;

    if (push_req && !push)                   overrun_d = 1'b1;
    if (wr && bus.address == 2'd1)           overrun_d = 1'b0;
    if (wr && bus.address == 2'd2)           div_d     = bus.writedata[15:0];
    if (wr && bus.address == 2'd3)           ctrl_d    = bus.writedata[CTRL_W-1:0];

    if ((wr && bus.address == 2'd3) || push) done_d = 1'b0;
    else if (done_pulse)                     done_d = 1'b1;

    case (bus.address)
      2'd1:    readdata_d = {16'd0, {(8-CW){1'b0}}, count_q, 4'd0,
                             overrun_q, busy, full, empty};
      2'd2:    readdata_d = {16'd0, div_q};
      2'd3:    readdata_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
      default: readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      baud_q     <= 16'd0;
      div_q      <= DIV_RESET;
      div_lat_q  <= DIV_RESET;
      bitcnt_q   <= 3'd0;
      data_q     <= 8'd0;
      tx_q       <= 1'b1;
      ctrl_q     <= '0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
      readdata_q <= 32'd0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      baud_q     <= baud_d;
      div_q      <= div_d;
      div_lat_q  <= div_lat_d;
      bitcnt_q   <= bitcnt_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      ctrl_q     <= ctrl_d;
      overrun_q  <= overrun_d;
      done_q     <= done_d;
      readdata_q <= readdata_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign bus.readdata = readdata_q;
  assign bus.irq      = (ctrl_q[0] & empty & ~busy) | (ctrl_q[1] & done_q);

endmodule

// File: tb/tb_sopc_uart_tx.sv
// tb_sopc_uart_tx -- scoreboard bench for sopc_uart_tx. Stimulus pushes the bytes the
// FIFO should accept into exp_q; an independent line monitor recognises each frame on
// tx, rebuilds the ideal waveform (start, LSB-first data, optional parity, stop, each
// DIVISOR+1 clocks) and compares it cycle by cycle.
module tb_sopc_uart_tx;
  logic clk = 1'b0;
  logic reset;
  logic tx;
  sopc_uart_tx_if bus();

  sopc_uart_tx #(.FIFO_AW(4), .DIV_RESET(16'd433)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cur_div  = 433;
  bit par_en   = 1'b0;
  bit par_odd  = 1'b0;
  logic [7:0] exp_q[$];
  int starts_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- bus tasks (entered just after a rising edge) -----------
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
    @(posedge clk); #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    bus_wr(2'd0, {24'd0, b});
  endtask

  task automatic set_div(input int d);
    cur_div = d;
    bus_wr(2'd2, d);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] st;
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      bus_rd(2'd1, st);
      if (st[2] == 1'b0 && st[0] == 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_timeout: transmitter still busy after %0d cycles", budget);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("exp_queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- line monitor / scoreboard ------------------------------
  initial begin : monitor
    int b, nb, errs;
    logic [7:0] eb, rx;
    logic [10:0] bits;
    bit aborted, pen, podd;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && tx === 1'b0) begin
        starts_q.push_back(cyc);
        b = cur_div + 1; pen = par_en; podd = par_odd;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_frame: start bit with empty scoreboard at cycle %0d", cyc);
          eb = 8'h00;
        end else begin
          eb = exp_q.pop_front();
        end
        bits = '1;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = eb[k];
        if (pen) begin
          bits[9] = (^eb) ^ podd;
          nb = 11;
        end else begin
          nb = 10;
        end
        errs = 0; aborted = 1'b0; rx = 8'h00;
        for (int c = 0; c < nb * b; c++) begin
          if (c > 0) @(negedge clk);
          if (reset === 1'b1) begin aborted = 1'b1; break; end
          if (tx !== bits[c / b]) errs++;
          if ((c % b) == (b / 2) && (c / b) >= 1 && (c / b) <= 8) rx[c / b - 1] = tx;
        end
        if (!aborted) begin
          chk("frame_byte", rx, eb);
          chk("frame_shape_errs", errs, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ------------------------------------------------
  initial begin : stim
    logic [31:0] rd;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_tx", tx, 1'b1);
    chk("rst_irq", bus.irq, 1'b0);
    chk("rst_readdata", bus.readdata, 32'd0);
    bus_rd(2'd1, rd); chk("rst_status", rd, 32'h1);
    bus_rd(2'd2, rd); chk("rst_divisor", rd, 32'd433);
    bus_rd(2'd3, rd); chk("rst_ctrl", rd, 32'd0);
    bus_rd(2'd0, rd); chk("txdata_reads_0", rd, 32'd0);

    // 1: DIVISOR=3, single 0x55 frame; busy while sending
    set_div(3);
    bus_rd(2'd2, rd); chk("divisor_rw", rd, 32'd3);
    bus_wr(2'd2, 32'hABCD_0003);
    bus_rd(2'd2, rd); chk("divisor_upper_ignored", rd, 32'd3);
    push_byte(8'h55, 1'b1);
    repeat (3) @(posedge clk); #1;
    bus_rd(2'd1, rd); chk("status_busy_midframe", rd, 32'h5);
    wait_idle(200);

    // 2: DIVISOR=0, two bytes back-to-back with no idle gap
    set_div(0);
    starts_q.delete();
    push_byte(8'hA5, 1'b1);
    push_byte(8'h3C, 1'b1);
    wait_idle(200);
    chk("b2b_frames", starts_q.size(), 2);
    if (starts_q.size() == 2) chk("b2b_gap", starts_q[1] - starts_q[0], 10);

    // 3: overrun. The first byte is popped the cycle after it lands, so of 18
    // consecutive pushes 17 fit (1 in flight + 16 queued) and the last is dropped.
    set_div(1000);
    for (int i = 0; i < 18; i++) push_byte(8'($urandom), i < 17);
    bus_rd(2'd1, rd); chk("status_full_overrun", rd, 32'h100E);
    bus_wr(2'd1, 32'h0);
    bus_rd(2'd1, rd); chk("status_overrun_cleared", rd, 32'h1006);
    set_div(1);  // takes effect from the second frame on
    wait_idle(20000);

    // 4: irq on empty, then irq on done
    bus_wr(2'd3, 32'h1);
    chk("irq_empty_idle", bus.irq, 1'b1);
    push_byte(8'h00, 1'b1);
    chk("irq_low_after_push", bus.irq, 1'b0);
    repeat (5) @(posedge clk); #1;
    chk("irq_low_midframe", bus.irq, 1'b0);
    wait_idle(200);
    chk("irq_empty_after_frame", bus.irq, 1'b1);
    bus_wr(2'd3, 32'h2);
    chk("irq_done_cleared_by_ctrl", bus.irq, 1'b0);
    push_byte(8'h81, 1'b1);
    wait_idle(200);
    chk("irq_done", bus.irq, 1'b1);
    bus_wr(2'd3, 32'h2);
    chk("irq_done_ctrl_clear", bus.irq, 1'b0);
    bus_wr(2'd3, 32'h0);

    // CTRL read-back width
    bus_wr(2'd3, 32'hF);
    bus_rd(2'd3, rd);
`ifdef UART_TX_PARITY_EN
    chk("ctrl_rw", rd, 32'hF);
`else
    chk("ctrl_rw", rd, 32'h3);
`endif
    bus_wr(2'd3, 32'h0);

    // Randomised traffic: random divisor, burst length, bytes and gaps
    for (int it = 0; it < 5; it++) begin
      set_div($urandom_range(0, 5));
      for (int j = 0, n = $urandom_range(1, 6); j < n; j++) begin
        push_byte(8'($urandom), 1'b1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      wait_idle(2000);
    end

`ifdef UART_TX_PARITY_EN
    // 6: even parity then odd parity on 0x07
    set_div(2);
    bus_wr(2'd3, 32'h4); par_en = 1'b1; par_odd = 1'b0;
    push_byte(8'h07, 1'b1);
    wait_idle(300);
    bus_wr(2'd3, 32'hC); par_odd = 1'b1;
    push_byte(8'h07, 1'b1);
    wait_idle(300);
    bus_wr(2'd3, 32'h0); par_en = 1'b0; par_odd = 1'b0;
`endif

    // 5: reset in the middle of the data bits of 0xFF with 3 more bytes queued
    set_div(3);
    push_byte(8'hFF, 1'b1);
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    repeat (10) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    cur_div = 433;
    chk("midframe_rst_tx", tx, 1'b1);
    chk("midframe_rst_readdata", bus.readdata, 32'd0);
    chk("midframe_rst_irq", bus.irq, 1'b0);
    reset = 1'b0;
    bus_rd(2'd1, rd); chk("midframe_rst_status", rd, 32'h1);
    bus_rd(2'd2, rd); chk("midframe_rst_divisor", rd, 32'd433);
    repeat (20) @(posedge clk); #1;
    chk("midframe_rst_line_idle", tx, 1'b1);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
